// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared types and constants for the median sequencer
package median_pkg;

    localparam int WIDTH = 4;
    localparam int MAX_N = 7;

    localparam int S_N3 = 3;
    localparam int S_N5 = 9;
    localparam int S_N7 = 18;

    localparam logic [1:0] MODE_N3  = 2'b00;
    localparam logic [1:0] MODE_N5  = 2'b01;
    localparam logic [1:0] MODE_N7  = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SORT = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    // Reserved mode falls through to the largest window.
    function automatic logic [2:0] mode_to_n(input logic [1:0] m);
        case (m)
            MODE_N3: return 3'd3;
            MODE_N5: return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/Comparator2.sv
// rtl/Comparator2.sv - combinational compare-swap of two unsigned operands
module Comparator2 #(
    parameter int W = 4
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] min,
    output logic [W-1:0] max
);

    always_comb begin
        if (A > B) begin
            min = B;
            max = A;
        end else begin
            min = A;
            max = B;
        end
    end

endmodule

// File: rtl/median_seq_ctrl.sv
// rtl/median_seq_ctrl.sv - frame loader with serial partial bubble sort returning the median
module median_seq_ctrl
    import median_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] median,
    input  logic             out_ready,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [2:0]       n_q, n_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       pass_q, pass_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] median_q, median_d;
    logic [WIDTH-1:0] buf_q [MAX_N];
    logic [WIDTH-1:0] buf_d [MAX_N];

    logic [WIDTH-1:0] cmp_min, cmp_max;
    logic [2:0]       pass_end, last_pass;
    logic             accept, retire;

    Comparator2 #(.W(WIDTH)) u_cmp (
        .A   (buf_q[idx_q]),
        .B   (buf_q[idx_q + 3'd1]),
        .min (cmp_min),
        .max (cmp_max)
    );

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign median    = median_q;

    assign accept    = in_valid && in_ready;
    assign retire    = out_valid_q && out_ready;
    assign pass_end  = n_q - 3'd2 - pass_q;
    assign last_pass = (n_q - 3'd1) >> 1;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        pass_d      = pass_q;
        out_valid_d = out_valid_q;
        median_d    = median_q;
        buf_d       = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    n_d      = mode_to_n(mode);
                    buf_d[0] = in_data;
                    idx_d    = 3'd1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    buf_d[idx_q] = in_data;
                    if (idx_q == n_q - 3'd1) begin
                        idx_d   = 3'd0;
                        pass_d  = 3'd0;
                        state_d = ST_SORT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_SORT: begin
                buf_d[idx_q]        = cmp_min;
                buf_d[idx_q + 3'd1] = cmp_max;
                if (idx_q == pass_end) begin
                    idx_d  = 3'd0;
                    pass_d = pass_q + 3'd1;
                    // The final compare of the last pass settles buf[(N-1)/2] as its max.
                    if (pass_q == last_pass) begin
                        pass_d      = 3'd0;
                        median_d    = cmp_max;
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_OUT: begin
                if (retire) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            n_q         <= 3'd7;
            idx_q       <= 3'd0;
            pass_q      <= 3'd0;
            out_valid_q <= 1'b0;
            median_q    <= '0;
            for (int i = 0; i < MAX_N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            pass_q      <= pass_d;
            out_valid_q <= out_valid_d;
            median_q    <= median_d;
            buf_q       <= buf_d;
        end
    end

endmodule

// File: doc/median_seq_ctrl.md
MEDIAN_SEQ_CTRL -- requirements
Module: median_seq_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock; the block's only clock.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 mode  input  2  window size: 2'b00=3, 2'b01=5, 2'b10=7, 2'b11=reserved, treated as 7; sampled only with the first sample of a frame.
REQ-004 in_valid  input  1  sample valid.
REQ-005 in_data  input  4  unsigned sample.
REQ-006 in_ready  output  1  block can accept a sample this cycle.
REQ-007 out_valid  output  1  median result valid.
REQ-008 median  output  4  median of the current frame.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 A sample SHALL transfer on a rising edge where in_valid and in_ready are both 1; out_valid and out_ready both 1 SHALL retire the result.
REQ-012 FSM states SHALL be IDLE, LOAD, SORT and OUT.
REQ-013 in_ready SHALL be 1 in IDLE and LOAD and 0 in SORT and OUT.
REQ-014 IDLE: an accepted sample SHALL latch mode into N, store the sample in buf[0] and go to LOAD (N=3,5,7).
REQ-015 LOAD: the k-th accepted sample SHALL be stored in buf[k-1]; acceptance of sample N SHALL go to SORT; idle cycles (in_valid=0) SHALL hold state.
REQ-016 SORT SHALL run a partial bubble sort with exactly one compare-swap per cycle through a single Comparator2 instance.
REQ-017 Each SORT cycle SHALL write min to buf[j] and max to buf[j+1].
REQ-018 Pass p SHALL cover j=0..N-2-p; passes p=0..(N+1)/2-1 SHALL run, then SORT SHALL stop.
REQ-019 Sort cycle count S SHALL be exactly 3 for N=3, 9 for N=5 and 18 for N=7.
REQ-020 The last compare edge SHALL enter OUT with out_valid=1 and median=buf[(N-1)/2]; out_valid SHALL rise exactly S edges after the last-sample accept edge.
REQ-021 OUT: out_valid and median SHALL hold stable while out_ready=0.
REQ-022 OUT: the retire edge SHALL return to IDLE with out_valid=0.
REQ-023 A new frame's first sample SHALL be accepted at the earliest in the cycle after retire.
REQ-024 Equal operands SHALL produce no swap-order dependence: min=max=value.
REQ-025 Pass and index counters SHALL be 3 bits each; no arithmetic SHALL exceed 4-bit data width; no overflow is possible.
REQ-026 mode changes after the first sample SHALL NOT affect the current frame.

Reset
REQ-027 rst_n=0 SHALL force, asynchronously and regardless of state (including mid-LOAD or mid-SORT): state=IDLE, out_valid=0, median=0, busy=0, all buf entries=0, counters=0, N=7.
REQ-028 After rst_n deassertion, in_ready SHALL be 1 on the first clock; partial frames SHALL be discarded.

Structure
REQ-029 Package median_pkg SHALL hold the state enum, the mode encodings, WIDTH=4, MAX_N=7 and the S constants (3/9/18).
REQ-030 The compare-swap SHALL be one instance of the existing Comparator2 (A, B -> min, max); no other sub-module.
REQ-031 buf SHALL be 7x4-bit registers; only the first N entries SHALL be used.

Verification
REQ-032 mode=00, samples 7,2,5, out_ready=1 -> out_valid 3 edges after last accept, median=5.
REQ-033 mode=01, samples 9,1,15,3,8 -> out_valid 9 edges after last accept, median=8.
REQ-034 mode=10, samples 6,5,4,3,2,1,0 with in_valid gaps inserted -> median=3 18 edges after last accept; in_ready=0 throughout SORT.
REQ-035 mode=11, seven samples of 15 -> median=15 (reserved mode handled as 7).
REQ-036 out_ready held 0 for 5 cycles in OUT -> median and out_valid stable; retire -> IDLE, in_ready=1.
REQ-037 rst_n pulsed low mid-SORT of a 7-frame -> immediate out_valid=0 and busy=0; next frame 4,4,1 (mode=00) -> median=4.
